// File: rtl/mdu_scheduler.sv
// Issue/hazard scheduler for the HI/LO multiply-divide unit: tracks the
// in-flight mult/div latency, pulses operand capture and result write, and flags illegal issues.
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E_start,
  input  logic [3:0] E_MDUCtrl,
  input  logic       D_md,
  input  logic       D_mt,
  input  logic       D_mf,
  output logic       stall,
  output logic       busy,
  output logic       opLatch,
  output logic [3:0] opSel,
  output logic       resWrite,
  output logic       wrHI,
  output logic       wrLO,
  output logic       protoErr
);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] op_sel_nxt;
  logic       proto_nxt;

  logic in_flight;
  logic is_md_op;
  logic is_mt_op;
  logic issue;
  logic err_event;

  assign in_flight = (state != IDLE);
  assign is_md_op  = (E_MDUCtrl >= 4'd1) && (E_MDUCtrl <= 4'd4);
  assign is_mt_op  = (E_MDUCtrl == 4'd5) || (E_MDUCtrl == 4'd6);
  assign issue     = E_start && is_md_op && !in_flight;
  // Any start or move-to while busy, or a start with a non-mult/div op, is a protocol error.
  assign err_event = (E_start && in_flight) || (is_mt_op && in_flight) ||
                     (E_start && !is_md_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      opSel    <= 4'd0;
      protoErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      opSel    <= op_sel_nxt;
      protoErr <= proto_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_sel_nxt = opSel;
    proto_nxt  = protoErr | err_event;
    case (state)
      IDLE: begin
        if (issue) begin
          op_sel_nxt = E_MDUCtrl;
          if (E_MDUCtrl <= 4'd2) begin
            state_nxt = RUN_MUL;
            cnt_nxt   = MULT_LAT;
          end else begin
            state_nxt = RUN_DIV;
            cnt_nxt   = DIV_LAT;
          end
        end
      end
      RUN_MUL, RUN_DIV: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // opLatch is gated by reset so no capture pulse escapes while reset is held.
  always_comb begin
    busy     = in_flight;
    opLatch  = issue && reset;
    resWrite = in_flight && (cnt == 4'd1);
    stall    = (D_md | D_mt | D_mf) & (E_start | in_flight);
    wrHI     = (E_MDUCtrl == 4'd5) && !in_flight;
    wrLO     = (E_MDUCtrl == 4'd6) && !in_flight;
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed self-checking bench for mdu_scheduler at default latencies (mult 5, div 10).
module tb_mdu_scheduler;

  logic       clk;
  logic       reset;
  logic       E_start;
  logic [3:0] E_MDUCtrl;
  logic       D_md, D_mt, D_mf;
  logic       stall, busy, opLatch, resWrite, wrHI, wrLO, protoErr;
  logic [3:0] opSel;

  int errors = 0;
  int checks = 0;

  mdu_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .E_start  (E_start),
    .E_MDUCtrl(E_MDUCtrl),
    .D_md     (D_md),
    .D_mt     (D_mt),
    .D_mf     (D_mf),
    .stall    (stall),
    .busy     (busy),
    .opLatch  (opLatch),
    .opSel    (opSel),
    .resWrite (resWrite),
    .wrHI     (wrHI),
    .wrLO     (wrLO),
    .protoErr (protoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    E_start   = 1'b0;
    E_MDUCtrl = 4'd0;
    D_md      = 1'b0;
    D_mt      = 1'b0;
    D_mf      = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released and the DUT idle.
  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    E_start   = 1'b1;
    E_MDUCtrl = 4'd1;
    D_md      = 1'b1;
    #2;
    checks++; if (opLatch !== 1'b0) begin errors++; $display("[TB] FAIL rst_opLatch got=%b exp=0", opLatch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (resWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_resWrite got=%b exp=0", resWrite); end
    checks++; if (opSel !== 4'd0) begin errors++; $display("[TB] FAIL rst_opSel got=%0d exp=0", opSel); end
    checks++; if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL rst_protoErr got=%b exp=0", protoErr); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall got=%b exp=1", stall); end
    E_start   = 1'b0;
    E_MDUCtrl = 4'd5;
    #1;
    checks++; if (wrHI !== 1'b1) begin errors++; $display("[TB] FAIL rst_wrHI got=%b exp=1", wrHI); end
    @(posedge clk);
    #1;
    apply_reset();
  endtask

  task automatic test_mult();
    for (int cyc = 0; cyc <= 6; cyc++) begin
      E_start   = (cyc == 0);
      E_MDUCtrl = (cyc == 0) ? 4'd1 : 4'd0;
      @(negedge clk);
      checks++; if (opLatch !== (cyc == 0)) begin errors++; $display("[TB] FAIL mult_opLatch c%0d got=%b exp=%b", cyc, opLatch, cyc == 0); end
      checks++; if (busy !== (cyc >= 1 && cyc <= 5)) begin errors++; $display("[TB] FAIL mult_busy c%0d got=%b exp=%b", cyc, busy, cyc >= 1 && cyc <= 5); end
      checks++; if (resWrite !== (cyc == 5)) begin errors++; $display("[TB] FAIL mult_resWrite c%0d got=%b exp=%b", cyc, resWrite, cyc == 5); end
      if (cyc >= 1) begin
        checks++; if (opSel !== 4'd1) begin errors++; $display("[TB] FAIL mult_opSel c%0d got=%0d exp=1", cyc, opSel); end
      end
      next_cycle();
    end
    checks++; if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL mult_protoErr got=%b exp=0", protoErr); end
  endtask

  task automatic test_divu_stall();
    for (int cyc = 0; cyc <= 12; cyc++) begin
      E_start   = (cyc == 0);
      E_MDUCtrl = (cyc == 0) ? 4'd4 : 4'd0;
      D_mf      = 1'b1;
      @(negedge clk);
      checks++; if (stall !== (cyc <= 10)) begin errors++; $display("[TB] FAIL divu_stall c%0d got=%b exp=%b", cyc, stall, cyc <= 10); end
      checks++; if (resWrite !== (cyc == 10)) begin errors++; $display("[TB] FAIL divu_resWrite c%0d got=%b exp=%b", cyc, resWrite, cyc == 10); end
      checks++; if (busy !== (cyc >= 1 && cyc <= 10)) begin errors++; $display("[TB] FAIL divu_busy c%0d got=%b exp=%b", cyc, busy, cyc >= 1 && cyc <= 10); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_move_to();
    E_MDUCtrl = 4'd5;
    D_mt      = 1'b1;
    @(negedge clk);
    checks++; if (wrHI !== 1'b1) begin errors++; $display("[TB] FAIL mthi_wrHI got=%b exp=1", wrHI); end
    checks++; if (wrLO !== 1'b0) begin errors++; $display("[TB] FAIL mthi_wrLO got=%b exp=0", wrLO); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mthi_stall got=%b exp=0", stall); end
    next_cycle();
    D_mt      = 1'b0;
    E_start   = 1'b1;
    E_MDUCtrl = 4'd1;
    next_cycle();
    E_start   = 1'b0;
    E_MDUCtrl = 4'd6;
    @(negedge clk);
    checks++; if (wrLO !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy_wrLO got=%b exp=0", wrLO); end
    checks++; if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_protoErr_pre got=%b exp=0", protoErr); end
    next_cycle();
    E_MDUCtrl = 4'd0;
    @(negedge clk);
    checks++; if (protoErr !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_protoErr got=%b exp=1", protoErr); end
    for (int i = 0; i < 5; i++) next_cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_done_busy got=%b exp=0", busy); end
    checks++; if (protoErr !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_sticky got=%b exp=1", protoErr); end
    apply_reset();
  endtask

  task automatic test_div_ignore();
    for (int cyc = 0; cyc <= 11; cyc++) begin
      E_start   = (cyc == 0) || (cyc == 3);
      E_MDUCtrl = (cyc == 0) ? 4'd3 : (cyc == 3) ? 4'd1 : 4'd0;
      @(negedge clk);
      checks++; if (opLatch !== (cyc == 0)) begin errors++; $display("[TB] FAIL divig_opLatch c%0d got=%b exp=%b", cyc, opLatch, cyc == 0); end
      checks++; if (resWrite !== (cyc == 10)) begin errors++; $display("[TB] FAIL divig_resWrite c%0d got=%b exp=%b", cyc, resWrite, cyc == 10); end
      checks++; if (protoErr !== (cyc >= 4)) begin errors++; $display("[TB] FAIL divig_protoErr c%0d got=%b exp=%b", cyc, protoErr, cyc >= 4); end
      if (cyc >= 1) begin
        checks++; if (opSel !== 4'd3) begin errors++; $display("[TB] FAIL divig_opSel c%0d got=%0d exp=3", cyc, opSel); end
      end
      next_cycle();
    end
    apply_reset();
  endtask

  task automatic test_reset_abort();
    E_start   = 1'b1;
    E_MDUCtrl = 4'd1;
    next_cycle();
    clear_inputs();
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (opSel !== 4'd0) begin errors++; $display("[TB] FAIL abort_opSel got=%0d exp=0", opSel); end
    checks++; if (resWrite !== 1'b0) begin errors++; $display("[TB] FAIL abort_resWrite got=%b exp=0", resWrite); end
    next_cycle();
    reset = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++; if (resWrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_quiet c%0d got=%b%b exp=00", cyc, resWrite, busy); end
      next_cycle();
    end
    test_mult();
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc <= 12; cyc++) begin
      E_start   = (cyc == 0) || (cyc == 6);
      E_MDUCtrl = E_start ? 4'd1 : 4'd0;
      @(negedge clk);
      checks++; if (opLatch !== (cyc == 0 || cyc == 6)) begin errors++; $display("[TB] FAIL b2b_opLatch c%0d got=%b exp=%b", cyc, opLatch, cyc == 0 || cyc == 6); end
      checks++; if (resWrite !== (cyc == 5 || cyc == 11)) begin errors++; $display("[TB] FAIL b2b_resWrite c%0d got=%b exp=%b", cyc, resWrite, cyc == 5 || cyc == 11); end
      checks++; if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL b2b_protoErr c%0d got=%b exp=0", cyc, protoErr); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_illegal();
    E_start   = 1'b1;
    E_MDUCtrl = 4'd7;
    @(negedge clk);
    checks++; if (opLatch !== 1'b0) begin errors++; $display("[TB] FAIL badop_opLatch got=%b exp=0", opLatch); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL badop_busy got=%b exp=0", busy); end
    checks++; if (protoErr !== 1'b1) begin errors++; $display("[TB] FAIL badop_protoErr got=%b exp=1", protoErr); end
    next_cycle();
    apply_reset();

    E_MDUCtrl = 4'd1;
    @(negedge clk);
    checks++; if (opLatch !== 1'b0) begin errors++; $display("[TB] FAIL nostart_opLatch got=%b exp=0", opLatch); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || protoErr !== 1'b0) begin errors++; $display("[TB] FAIL nostart_state got=%b%b exp=00", busy, protoErr); end
    next_cycle();

    // A start in the result-write cycle is still illegal and must not restart.
    for (int cyc = 0; cyc <= 6; cyc++) begin
      E_start   = (cyc == 0) || (cyc == 5);
      E_MDUCtrl = E_start ? 4'd1 : 4'd0;
      @(negedge clk);
      if (cyc == 5) begin
        checks++; if (resWrite !== 1'b1 || opLatch !== 1'b0) begin errors++; $display("[TB] FAIL rwstart_pulses got=%b%b exp=10", resWrite, opLatch); end
      end
      if (cyc == 6) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rwstart_busy got=%b exp=0", busy); end
        checks++; if (protoErr !== 1'b1) begin errors++; $display("[TB] FAIL rwstart_protoErr got=%b exp=1", protoErr); end
      end
      next_cycle();
    end
    apply_reset();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_mult();
    test_divu_stall();
    test_move_to();
    test_div_ignore();
    test_reset_abort();
    test_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
MDU_SCHEDULER -- requirements
Module: mdu_scheduler

Interface
REQ-001 Parameter MULT_CYCLES, default 5, cycles HI/LO stay busy after a mult/multu issue; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10, cycles HI/LO stay busy after a div/divu issue; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-005 E_start  input  1  EX-stage instruction is mult/multu/div/divu.
REQ-006 E_MDUCtrl  input  4  EX-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none.
REQ-007 D_md, D_mt, D_mf  input  1 each  D-stage instruction is mult/div class, mthi/mtlo, mfhi/mflo.
REQ-008 stall  output  1  request to hazard unit to freeze F/D and bubble E.
REQ-009 busy  output  1  an issued mult/div is in flight.
REQ-010 opLatch  output  1  one-cycle pulse: MDU datapath captures operands and op this cycle.
REQ-011 opSel  output  4  op code of the in-flight or last issued mult/div.
REQ-012 resWrite  output  1  one-cycle pulse: MDU datapath writes its result into HI and LO this cycle.
REQ-013 wrHI, wrLO  output  1 each  combinational write enables for mthi/mtlo.
REQ-014 protoErr  output  1  sticky flag: illegal issue observed.

Function
REQ-015 States SHALL be IDLE, RUN_MUL, RUN_DIV; 4-bit down-counter cnt.
REQ-016 Issue: in IDLE with E_start=1 and E_MDUCtrl in 1..4, opLatch SHALL be 1 that cycle; at the edge opSel<=E_MDUCtrl, state<=RUN_MUL (1,2) or RUN_DIV (3,4), cnt<=MULT_CYCLES or DIV_CYCLES.
REQ-017 busy SHALL equal (state!=IDLE); busy is high exactly N cycles after the issue edge, N = selected latency.
REQ-018 In RUN_*, cnt SHALL decrement by 1 per edge; resWrite SHALL be 1 in the cycle cnt==1; at that edge state<=IDLE.
REQ-019 Back-to-back: E_start in the cycle resWrite=1 SHALL be treated as illegal (REQ-022); a new issue is legal from the first IDLE cycle.
REQ-020 stall SHALL equal (D_md|D_mt|D_mf) & (E_start|busy), purely combinational.
REQ-021 wrHI SHALL equal (E_MDUCtrl==5)&~busy; wrLO SHALL equal (E_MDUCtrl==6)&~busy.
REQ-022 E_start=1 while busy, or E_MDUCtrl in 5..6 while busy: request ignored (no restart, no wrHI/wrLO, counter unaffected), protoErr<=1 at the edge.
REQ-023 E_start=1 with E_MDUCtrl not in 1..4: ignored, protoErr<=1.
REQ-024 protoErr SHALL clear only on reset.
REQ-025 E_start=0 with E_MDUCtrl in 1..4: no issue, no error.
REQ-026 No cycle SHALL have opLatch and resWrite both 1.

Reset
REQ-027 reset low: state=IDLE, cnt=0, opSel=0, protoErr=0; busy, opLatch, resWrite SHALL be 0 immediately.
REQ-028 Reset mid-operation SHALL abort the op with no resWrite pulse; after release, first edge with E_start may issue.
REQ-029 wrHI, wrLO, stall remain combinational from inputs and the cleared state during reset.

Verification
REQ-030 Issue mult (E_start=1, E_MDUCtrl=1) at cycle 0 -> opLatch=1 cycle 0; busy=1 cycles 1-5; resWrite=1 cycle 5 only; busy=0 cycle 6.
REQ-031 Issue divu at cycle 0, D_mf=1 cycles 0-12 -> stall=1 cycles 0-10, stall=0 cycle 11; resWrite in cycle 10.
REQ-032 mthi (E_MDUCtrl=5) while IDLE -> wrHI=1 same cycle, stall=0; mtlo while busy -> wrLO=0, protoErr=1 next cycle.
REQ-033 E_start with E_MDUCtrl=1 at cycle 3 of a div -> ignored, resWrite still in cycle 10, opSel stays 3, protoErr=1.
REQ-034 reset low at cycle 2 of a mult -> busy=0 immediately, no resWrite ever, opSel=0; new mult after release completes in 5 cycles.
REQ-035 Issue mult at cycle 0 and again at cycle 6 -> two resWrite pulses, cycles 5 and 11; protoErr stays 0.
